// File: rtl/leb128_defs.sv
// Shared encodings and helpers for the LEB128 immediate reader.
package leb128_defs;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        DECODE,
        DONE
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_MEM  = 2'd1;
    localparam logic [1:0] ERR_LONG = 2'd2;
    localparam logic [1:0] ERR_OVF  = 2'd3;

    localparam logic [3:0] MAX_LEN_NARROW = 4'd5;
    localparam logic [3:0] MAX_LEN_WIDE   = 4'd10;

    localparam int EXTRA_NARROW = 4;
    localparam int EXTRA_WIDE   = 9;

    // Payload bits of the final permitted byte that would not fit the target width.
    function automatic logic ovf_check(
        input logic [7:0] b,
        input logic       sgn,
        input logic       wide
    );
        logic bad;
        if (!wide && !sgn)
            bad = (b[6:4] != 3'd0);
        else if (!wide && sgn)
            bad = (b[6:3] != 4'h0) && (b[6:3] != 4'hF);
        else if (!sgn)
            bad = (b[6:1] != 6'd0);
        else
            bad = (b[6:1] != {6{b[0]}});
        return bad;
    endfunction

    function automatic logic [63:0] sext_at(
        input logic [63:0] v,
        input logic [3:0]  len
    );
        logic [6:0]  bits;
        logic [5:0]  p;
        logic [63:0] mask;
        bits = 7'(len) * 7'd7;
        p    = 6'(bits - 7'd1);
        mask = ~64'd0 << bits;
        if (len == 4'd0 || len > 4'd9)
            return v;
        return v[p] ? (v | mask) : (v & ~mask);
    endfunction

endpackage

// File: rtl/leb128_reader.sv
// One-shot windowed ROM fetch followed by byte-serial LEB128 decode.
module leb128_reader
    import leb128_defs::*;
#(
    parameter int MEM_DEPTH = 4,
    parameter int MEM_EXTRA = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [MEM_DEPTH:0]            addr,
    input  logic                          signed_mode,
    input  logic                          wide,
    output logic                          busy,
    output logic                          done,
    output logic [63:0]                   value,
    output logic [3:0]                    length,
    output logic [1:0]                    error,
    output logic [MEM_DEPTH:0]            mem_addr,
    output logic [MEM_EXTRA-1:0]          mem_extra,
    input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
    input  logic                          mem_error
);

    localparam int WIN_W = (2**MEM_EXTRA) * 8;

    state_t             state;
    logic               sgn_q;
    logic               wide_q;
    logic [WIN_W-1:0]   win;
    logic [63:0]        acc;
    logic [3:0]         idx;

    logic [7:0]         cur;
    logic [6:0]         shamt;
    logic [63:0]        acc_next;
    logic [63:0]        sx;
    logic [63:0]        result;
    logic [3:0]         len_n;
    logic               last;
    logic               ovf;

    always_comb begin
        cur      = win[{idx, 3'b000} +: 8];
        shamt    = 7'({idx, 3'b000}) - 7'({3'b000, idx});
        acc_next = acc | ({57'd0, cur[6:0]} << shamt);
        len_n    = idx + 4'd1;
        last     = (idx == (wide_q ? MAX_LEN_WIDE - 4'd1
                                   : MAX_LEN_NARROW - 4'd1));
        ovf      = last && ovf_check(cur, sgn_q, wide_q);
        sx       = sext_at(acc_next, len_n);
        result   = acc_next;
        if (sgn_q && wide_q)
            result = sx;
        else if (sgn_q)
            result = {{32{sx[31]}}, sx[31:0]};
        else if (!wide_q)
            result = {32'd0, acc_next[31:0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sgn_q     <= 1'b0;
            wide_q    <= 1'b0;
            win       <= '0;
            acc       <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            value     <= '0;
            length    <= '0;
            error     <= ERR_NONE;
            mem_addr  <= '0;
            mem_extra <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sgn_q     <= signed_mode;
                        wide_q    <= wide;
                        mem_addr  <= addr;
                        mem_extra <= wide ? MEM_EXTRA'(EXTRA_WIDE)
                                          : MEM_EXTRA'(EXTRA_NARROW);
                        busy      <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    win    <= mem_data;
                    value  <= '0;
                    length <= '0;
                    acc    <= '0;
                    idx    <= '0;
                    if (mem_error) begin
                        error <= ERR_MEM;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        error <= ERR_NONE;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    acc <= acc_next;
                    idx <= len_n;
                    // Continuation on the final byte outranks overflow.
                    if (cur[7] && last) begin
                        error  <= ERR_LONG;
                        value  <= '0;
                        length <= len_n;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (ovf) begin
                        error  <= ERR_OVF;
                        value  <= '0;
                        length <= len_n;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (!cur[7]) begin
                        error  <= ERR_NONE;
                        value  <= result;
                        length <= len_n;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leb128_reader.sv
// Directed-vector bench for leb128_reader with a registered 32-byte ROM.
module tb_leb128_reader;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [4:0]   addr;
    logic         signed_mode;
    logic         wide;
    logic         busy;
    logic         done;
    logic [63:0]  value;
    logic [3:0]   length;
    logic [1:0]   error;
    logic [4:0]   mem_addr;
    logic [3:0]   mem_extra;
    logic [127:0] mem_data = '0;
    logic         mem_error = 1'b0;

    logic [7:0] rom [32];

    int checks = 0;
    int failures = 0;
    int cur_vec = -1;

    leb128_reader #(.MEM_DEPTH(4), .MEM_EXTRA(4)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr),
        .signed_mode(signed_mode), .wide(wide), .busy(busy),
        .done(done), .value(value), .length(length), .error(error),
        .mem_addr(mem_addr), .mem_extra(mem_extra),
        .mem_data(mem_data), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (int'(mem_addr) + i < 32)
                mem_data[8*i +: 8] <= rom[int'(mem_addr) + i];
            else
                mem_data[8*i +: 8] <= 8'h00;
        end
        mem_error <= (int'(mem_addr) + int'(mem_extra)) > 31;
    end

    typedef struct {
        logic [4:0]  a;
        int          nb;
        logic [79:0] bytes;
        logic        s;
        logic        w;
        logic [63:0] v;
        logic [3:0]  len;
        logic [1:0]  err;
        int          cyc;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h",
                     name, cur_vec, act, exp);
        end
    endtask

    task automatic load(input logic [4:0] a, input int nb,
                        input logic [79:0] bytes);
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        for (int k = 0; k < nb; k++)
            rom[int'(a) + k] = bytes[8*(nb-1-k) +: 8];
    endtask

    task automatic run(input logic [4:0] a, input logic s, input logic w,
                       output logic [63:0] v, output logic [3:0] len,
                       output logic [1:0] err, output int cyc);
        logic got;
        got = 1'b0;
        cyc = 0;
        v = '0;
        len = '0;
        err = '0;
        @(negedge clk);
        addr = a;
        signed_mode = s;
        wide = w;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1'b1;
                cyc = c + 1;
                v = value;
                len = length;
                err = error;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL timeout vec=%0d actual=no_done required=done",
                     cur_vec);
        end
        @(posedge clk);
        #1;
        chk("done_pulse_width", 64'(done), 64'd0);
    endtask

    logic [63:0] rv;
    logic [3:0]  rl;
    logic [1:0]  re;
    int          rc;
    int          ndone;
    logic [63:0] seen_v;
    logic [3:0]  seen_l;

    initial begin
        vecs[0]  = '{5'd0,  3,  80'hE58E26,               1'b0, 1'b1,
                     64'd624485, 4'd3, 2'd0, 6};
        vecs[1]  = '{5'd3,  3,  80'hC0BB78,               1'b1, 1'b0,
                     64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 2'd0, 6};
        vecs[2]  = '{5'd5,  1,  80'h7F,                   1'b1, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 2'd0, 4};
        vecs[3]  = '{5'd5,  1,  80'h7F,                   1'b0, 1'b1,
                     64'd127, 4'd1, 2'd0, 4};
        vecs[4]  = '{5'd8,  5,  80'hFFFFFFFF0F,           1'b0, 1'b0,
                     64'h0000_0000_FFFF_FFFF, 4'd5, 2'd0, 8};
        vecs[5]  = '{5'd8,  5,  80'hFFFFFFFF1F,           1'b0, 1'b0,
                     64'd0, 4'd5, 2'd3, 8};
        vecs[6]  = '{5'd12, 10, 80'h80808080808080808080, 1'b0, 1'b1,
                     64'd0, 4'd10, 2'd2, 13};
        vecs[7]  = '{5'd28, 1,  80'h00,                   1'b0, 1'b1,
                     64'd0, 4'd0, 2'd1, 3};
        vecs[8]  = '{5'd20, 1,  80'h40,                   1'b1, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFC0, 4'd1, 2'd0, 4};
        vecs[9]  = '{5'd2,  10, 80'hFFFFFFFFFFFFFFFFFF01, 1'b0, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 2'd0, 13};
        vecs[10] = '{5'd4,  5,  80'hFFFFFFFF7F,           1'b1, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFF, 4'd5, 2'd0, 8};
        vecs[11] = '{5'd4,  5,  80'hFFFFFFFF4F,           1'b1, 1'b0,
                     64'd0, 4'd5, 2'd3, 8};
        vecs[12] = '{5'd0,  5,  80'h8080808080,           1'b0, 1'b0,
                     64'd0, 4'd5, 2'd2, 8};
        vecs[13] = '{5'd16, 2,  80'h807F,                 1'b1, 1'b1,
                     64'hFFFF_FFFF_FFFF_FF80, 4'd2, 2'd0, 5};
        vecs[14] = '{5'd0,  10, 80'h8080808080808080807F, 1'b1, 1'b1,
                     64'h8000_0000_0000_0000, 4'd10, 2'd0, 13};
        vecs[15] = '{5'd0,  10, 80'h8080808080808080807E, 1'b1, 1'b1,
                     64'd0, 4'd10, 2'd3, 13};

        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        reset = 1'b0;
        start = 1'b0;
        addr = '0;
        signed_mode = 1'b0;
        wide = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_value", value, 64'd0);
        chk("rst_length", 64'(length), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_extra", 64'(mem_extra), 64'd0);
        reset = 1'b1;

        for (int n = 0; n < 16; n++) begin
            cur_vec = n;
            load(vecs[n].a, vecs[n].nb, vecs[n].bytes);
            run(vecs[n].a, vecs[n].s, vecs[n].w, rv, rl, re, rc);
            chk("value", rv, vecs[n].v);
            chk("error", 64'(re), 64'(vecs[n].err));
            chk("done_cycle", 64'(rc), 64'(vecs[n].cyc));
            if (vecs[n].err == 2'd0 || vecs[n].err == 2'd1)
                chk("length", 64'(rl), 64'(vecs[n].len));
            chk("mem_addr_hold", 64'(mem_addr), 64'(vecs[n].a));
            chk("mem_extra_hold", 64'(mem_extra),
                vecs[n].w ? 64'd9 : 64'd4);
        end

        // Reset asserted in the middle of a long decode.
        cur_vec = 100;
        load(5'd2, 10, 80'hFFFFFFFFFFFFFFFFFF01);
        @(negedge clk);
        addr = 5'd2;
        signed_mode = 1'b0;
        wide = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("busy_in_decode", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_value", value, 64'd0);
        chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_no_done", 64'(ndone), 64'd0);

        cur_vec = 101;
        load(5'd0, 3, 80'hE58E26);
        run(5'd0, 1'b0, 1'b1, rv, rl, re, rc);
        chk("after_rst_value", rv, 64'd624485);
        chk("after_rst_length", 64'(rl), 64'd3);
        chk("after_rst_cycle", 64'(rc), 64'd6);

        // Extra start pulses while busy must be dropped.
        cur_vec = 102;
        load(5'd0, 3, 80'hE58E26);
        rom[10] = 8'h01;
        ndone = 0;
        seen_v = '0;
        seen_l = '0;
        @(negedge clk);
        addr = 5'd0;
        signed_mode = 1'b0;
        wide = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = (c == 2 || c == 4);
            addr = (c == 0) ? 5'd0 : 5'd10;
            if (done) begin
                ndone++;
                seen_v = value;
                seen_l = length;
            end
        end
        start = 1'b0;
        chk("busy_start_dones", 64'(ndone), 64'd1);
        chk("busy_start_value", seen_v, 64'd624485);
        chk("busy_start_length", 64'(seen_l), 64'd3);
        chk("busy_start_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/leb128_reader.md
# leb128_reader

Bytecode-side initiator for the genrom window interface: on a start request it issues one windowed ROM read (mem_addr / mem_extra), captures the returned byte window, and decodes one WebAssembly LEB128 immediate byte-serially (unsigned or signed, 32- or 64-bit). It sits between the CPU decode stage and the program ROM, giving the decoder a ready 64-bit immediate, its encoded length and an error code.

## Interface

- MEM_DEPTH, 4, ROM address width minus one; addresses are MEM_DEPTH+1 bits
- MEM_EXTRA, 4, width of mem_extra; data window is 2**MEM_EXTRA bytes, minimum 10 bytes, so MEM_EXTRA ≥ 4
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; low forces reset state immediately
- start  in  1  request; sampled only in IDLE
- addr  in  MEM_DEPTH+1  ROM byte address of first LEB128 byte
- signed_mode  in  1  1 = sLEB128, 0 = uLEB128
- wide  in  1  1 = 64-bit (max 10 bytes), 0 = 32-bit (max 5 bytes)
- busy  out  1  high from FETCH through DECODE
- done  out  1  one-cycle pulse, results valid
- value  out  64  decoded value; 32-bit signed results sign-extended to 64, unsigned zero-extended
- length  out  4  encoded bytes consumed (1–10)
- error  out  2  0 none, 1 mem_error, 2 too long, 3 overflow
- mem_addr  out  MEM_DEPTH+1  ROM address
- mem_extra  out  MEM_EXTRA  extra bytes requested beyond the first
- mem_data  in  2**MEM_EXTRA*8  ROM window; byte at mem_addr+i in bits [8i+7:8i]
- mem_error  in  1  ROM bounds error for the window

## Operation

- States: IDLE → FETCH → CAPTURE → DECODE → DONE → IDLE.
- IDLE: start=1 latches addr, signed_mode and wide → FETCH. start while not IDLE is ignored.
- FETCH: drive mem_addr=latched addr, mem_extra=4 (wide=0) or 9 (wide=1) → CAPTURE.
- CAPTURE: latch mem_data and mem_error. mem_error=1 → error=1, length=0, value=0, → DONE. Otherwise clear accumulator, byte index i=0, → DECODE.
- DECODE, one byte per cycle: acc |= byte[6:0] << 7i; i++.
  - byte[7]=0 → terminate.
  - Last permitted byte (i=4 narrow, i=9 wide) with byte[7]=1 → error 2. This check takes priority over overflow.
  - Overflow check on the last permitted byte:
    - Narrow unsigned: bits[6:4]≠0.
    - Narrow signed: bits[6:3] not all equal.
    - Wide unsigned: bits[6:1]≠0.
    - Wide signed: bits[6:1] not all equal to bit0.
    - Any violation → error 3.
- On termination: length=i+1.
  - Signed mode: sign-extend from bit 7·length−1. For wide=0, first sign-extend at bit 31, then to 64.
  - On any error, value=0.
- DONE: done=1 for one cycle → IDLE.
- value, length and error hold until the next CAPTURE.
- mem_addr and mem_extra hold their last values in IDLE.

## Timing

- start high at edge 0 → FETCH during cycle 1. ROM registers at edge 2. CAPTURE during cycle 2. DECODE cycles 3…n+2. done high during cycle n+3, where n = bytes decoded.
- mem_error path: done in cycle 3.
- Back-to-back: start may be high in the cycle after done; it is accepted then, since the block is in IDLE.
- Reset values: state IDLE, busy 0, done 0, value 0, length 0, error 0, mem_addr 0, mem_extra 0.
- Reset asserted mid-operation: immediate return to reset values, no done pulse, and the request is lost.

## Structure

- Shared package/header leb128_defs: state encodings (IDLE, FETCH, CAPTURE, DECODE, DONE), error codes (ERR_NONE=0, ERR_MEM=1, ERR_LONG=2, ERR_OVF=3), max lengths 5/10, mem_extra values 4/9.
- No sub-module. The FSM, byte mux and accumulator live in one module.
- The final-byte overflow check is a combinational function in leb128_defs.

## Test plan

- Unsigned wide, ROM bytes E5 8E 26 at addr 0, start at edge 0 → done in cycle 6, value 624485, length 3, error 0.
- signed_mode=1, wide=0, bytes C0 BB 78 → value 0xFFFF_FFFF_FFFE_1DC0 (−123456), length 3, error 0.
- Signed wide, single byte 7F → value all ones, length 1, done in cycle 4. Same byte unsigned → value 127.
- Unsigned narrow, bytes FF FF FF FF 0F → value 0xFFFF_FFFF, length 5, error 0.
  - Then bytes FF FF FF FF 1F → error 3, value 0.
- Wide, ten bytes 80 → error 2.
  - Window crossing rom_upper_bound (mem_error=1) → error 1, done in cycle 3.
- Reset driven low during DECODE → busy 0 immediately, no done pulse.
  - Next start after reset decodes normally.
- start pulsed while busy → ignored: exactly one done pulse, with the first request's result.
